// File: rtl/scs8hd_o21bai_evtmon_if.sv
// Report channel of the o21bai event monitor: snapshot payload plus valid/ready
// handshake and the sticky drop flag.
interface scs8hd_o21bai_evtmon_if #(
  parameter int unsigned CNT_W = 8
);
  logic             RPT_VALID;
  logic             RPT_READY;
  logic [CNT_W-1:0] RPT_DATA;
  logic             RPT_SAT;
  logic             RPT_DROP;

  modport master (
    output RPT_VALID,
    output RPT_DATA,
    output RPT_SAT,
    output RPT_DROP,
    input  RPT_READY
  );

  modport slave (
    input  RPT_VALID,
    input  RPT_DATA,
    input  RPT_SAT,
    input  RPT_DROP,
    output RPT_READY
  );
endinterface

// File: rtl/scs8hd_o21bai_evtmon.sv
// Synchronizes and deglitches the o21bai Y output, counts its qualified falling
// edges and hands snapshot counts out over a valid/ready report channel.
module scs8hd_o21bai_evtmon #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           Y,
  input  logic                           RD_REQ,
  output logic                           YF,
  output logic                           EVT,
  scs8hd_o21bai_evtmon_if.master         rpt
);

  localparam int unsigned RC_W = 4;
  localparam logic [RC_W-1:0]  FILT_LEN_RC = RC_W'(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    STABLE_HI = 2'd0,
    CHK_LO    = 2'd1,
    STABLE_LO = 2'd2,
    CHK_HI    = 2'd3
  } filt_state_e;

  logic             s1, s2;
  filt_state_e      state_q, state_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             yf_q, yf_d;
  logic             evt_q, evt_d;

  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic             sat, sat_d;
  logic             accept, reject;

  logic             rpt_valid_q;
  logic [CNT_W-1:0] rpt_data_q;
  logic             rpt_sat_q;
  logic             rpt_drop_q;

  // Two-flop synchronizer; only s2 is used downstream
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= Y;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= STABLE_HI;
      rc_q    <= '0;
      yf_q    <= 1'b1;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      yf_q    <= yf_d;
      evt_q   <= evt_d;
    end
  end

  // Deglitch filter: FILT_LEN consecutive mismatching samples flip YF
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    yf_d    = yf_q;
    evt_d   = 1'b0;
    unique case (state_q)
      STABLE_HI: begin
        if (!s2) begin
          if (FILT_LEN_RC == RC_W'(1)) begin
            state_d = STABLE_LO;
            rc_d    = '0;
            yf_d    = 1'b0;
            evt_d   = 1'b1;
          end else begin
            state_d = CHK_LO;
            rc_d    = RC_W'(1);
          end
        end
      end
      CHK_LO: begin
        if (s2) begin
          state_d = STABLE_HI;
          rc_d    = '0;
        end else if (rc_q + RC_W'(1) == FILT_LEN_RC) begin
          state_d = STABLE_LO;
          rc_d    = '0;
          yf_d    = 1'b0;
          evt_d   = 1'b1;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      STABLE_LO: begin
        if (s2) begin
          if (FILT_LEN_RC == RC_W'(1)) begin
            state_d = STABLE_HI;
            rc_d    = '0;
            yf_d    = 1'b1;
          end else begin
            state_d = CHK_HI;
            rc_d    = RC_W'(1);
          end
        end
      end
      CHK_HI: begin
        if (!s2) begin
          state_d = STABLE_LO;
          rc_d    = '0;
        end else if (rc_q + RC_W'(1) == FILT_LEN_RC) begin
          state_d = STABLE_HI;
          rc_d    = '0;
          yf_d    = 1'b1;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      default: begin
        state_d = STABLE_HI;
        rc_d    = '0;
        yf_d    = 1'b1;
      end
    endcase
  end

  // An event coinciding with a snapshot is carried into the fresh count
  always_comb begin
    accept  = RD_REQ & ~rpt_valid_q;
    reject  = RD_REQ & rpt_valid_q;
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    cnt_d   = cnt;
    if (accept) begin
      cnt_d = evt_q ? CNT_W'(1) : '0;
    end else if (evt_q) begin
      cnt_d = cnt_inc;
    end
    sat_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt         <= '0;
      sat         <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_data_q  <= '0;
      rpt_sat_q   <= 1'b0;
      rpt_drop_q  <= 1'b0;
    end else begin
      cnt <= cnt_d;
      sat <= sat_d;
      if (accept) begin
        rpt_valid_q <= 1'b1;
        rpt_data_q  <= cnt;
        rpt_sat_q   <= sat;
      end else if (rpt_valid_q && rpt.RPT_READY) begin
        rpt_valid_q <= 1'b0;
      end
      if (reject) begin
        rpt_drop_q <= 1'b1;
      end
    end
  end

  assign YF            = yf_q;
  assign EVT           = evt_q;
  assign rpt.RPT_VALID = rpt_valid_q;
  assign rpt.RPT_DATA  = rpt_data_q;
  assign rpt.RPT_SAT   = rpt_sat_q;
  assign rpt.RPT_DROP  = rpt_drop_q;

endmodule
